gf2_poly_divider: RTL and testbench
===================================

GF2_POLY_DIVIDER -- requirements
Module: gf2_poly_divider

Interface
REQ-001 Parameter: k, default 8, divisor width in bits; dividend and quotient are 2k bits wide, matching the nmultiplier product width.
REQ-002 clk  input  1  single clock; every register updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  dividend and divisor are valid this cycle.
REQ-005 in_ready  output  1  block can accept an operation.
REQ-006 dividend  input  2k  GF(2) polynomial; bit i is the coefficient of x^i.
REQ-007 divisor  input  k  GF(2) polynomial; bit i is the coefficient of x^i.
REQ-008 out_valid  output  1  result is held stable.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 quotient  output  2k  carry-less quotient.
REQ-011 remainder  output  k  carry-less remainder; bits at or above deg(divisor) are 0.
REQ-012 div_by_zero  output  1  asserted with out_valid when the divisor was 0.

Function
REQ-013 Arithmetic: all arithmetic is carry-less over GF(2) (addition is XOR), so that dividend == quotient*divisor XOR remainder, with deg(remainder) < deg(divisor).
REQ-014 FSM: the block shall have states IDLE, DIV and DONE.
REQ-015 IDLE: in_ready=1, out_valid=0.
REQ-016 Accept: an operation is accepted on an edge where in_valid && in_ready; the block captures dividend and divisor and computes d = deg(divisor), the index of the highest set bit.
REQ-017 Accept with a nonzero divisor: the block clears the accumulator acc (k bits) and the quotient register, loads the bit counter with 2k-1, and enters DIV.
REQ-018 Accept with a zero divisor: the block enters DONE on the next edge with quotient=0, remainder=0 and div_by_zero=1.
REQ-019 DIV step: one dividend bit per cycle, MSB first; per cycle, t = {acc[k-2:0], next dividend bit}, qbit = t[d], acc <= qbit ? t ^ divisor : t, and quotient <= {quotient[2k-2:0], qbit}.
REQ-020 DIV exit: after exactly 2k DIV cycles the block enters DONE; the counter reaching 0 marks the last step.
REQ-021 Latency: for a nonzero divisor, out_valid rises exactly 2k+1 edges after the accepting edge; for a zero divisor, 1 edge after.
REQ-022 DONE: out_valid=1 and in_ready=0; quotient, remainder and div_by_zero hold stable until out_valid && out_ready.
REQ-023 DONE exit: on out_valid && out_ready the block returns to IDLE, with in_ready=1 on the next cycle; there is no overlap between operations.
REQ-024 Busy: in_ready=0 in DIV and DONE; in_valid is ignored while in_ready=0.
REQ-025 Output register: quotient, remainder and div_by_zero are registered and update only on entry to DONE; they retain their values in IDLE.
REQ-026 Degenerate divisor: divisor=1 (d=0) yields quotient=dividend and remainder=0.
REQ-027 Large divisor: with d=k-1, t may have bit k-1 set; after the XOR, acc bit k-1 is always 0.

Reset
REQ-028 When rst=1 at an edge, the block shall enter IDLE with in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, acc=0 and counter=0.
REQ-029 Reset takes priority over any handshake and aborts an operation in DIV or DONE; the aborted result is never presented.

Structure
REQ-030 Shared package: gf2_pkg shall hold the state enum (IDLE, DIV, DONE) and the degree-width helper constant $clog2(k).
REQ-031 Sub-module: the block shall contain one sub-module, gf2_degree, a combinational priority encoder (k-bit input, outputs degree and zero flag).

Verification (k=4)
REQ-032 Exact division: dividend=8'h0F, divisor=4'b0011 -> quotient=8'h05, remainder=4'h0, out_valid at accept+9 edges.
REQ-033 Nonzero remainder: dividend=8'h0F, divisor=4'b0010 -> quotient=8'h07, remainder=4'h1.
REQ-034 Field modulus: dividend=8'h80, divisor=4'b1011 -> quotient=8'h17, remainder=4'h1.
REQ-035 Zero and unit divisors: divisor=0 -> div_by_zero=1, quotient=0, remainder=0 after 1 edge; divisor=1, dividend=8'hA5 -> quotient=8'hA5, remainder=0.
REQ-036 Backpressure: out_ready held 0 for 5 cycles -> outputs stable and in_valid ignored throughout; after out_ready=1 the block returns to IDLE and in_ready=1 on the next cycle.
REQ-037 Abort and random: rst asserted mid-DIV -> IDLE with all outputs 0 and no out_valid pulse; random operands -> quotient*divisor XOR remainder == dividend, checked against the nmultiplier model.

Source files
------------

// File: rtl/gf2_pkg.sv
// Shared types and helpers for the GF(2) polynomial divider.
// Holds the FSM state encoding and the width of a degree index.
package gf2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to hold a degree 0..k-1; never narrower than one bit.
  function automatic int deg_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/gf2_degree.sv
// Combinational priority encoder: index of the highest set bit of a polynomial,
// plus a flag for the all-zero polynomial.
module gf2_degree
  import gf2_pkg::*;
#(
  parameter int K  = 8,
  parameter int DW = deg_width(K)
) (
  input  logic [K-1:0]  i_poly,
  output logic [DW-1:0] o_deg,
  output logic          o_zero
);

  always_comb begin
    o_deg  = '0;
    o_zero = (i_poly == '0);
    for (int i = 0; i < K; i++) begin
      if (i_poly[i]) o_deg = DW'(i);
    end
  end

endmodule

// File: rtl/gf2_poly_divider.sv
// Bit-serial carry-less polynomial divider: one dividend bit per cycle, MSB first.
// Handshake: a transfer happens on a rising edge where valid && ready, on both ports.
module gf2_poly_divider
  import gf2_pkg::*;
#(
  parameter int k = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*k-1:0] dividend,
  input  logic [k-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*k-1:0] quotient,
  output logic [k-1:0]   remainder,
  output logic           div_by_zero,
  output state_t         o_state
);

  localparam int DW = deg_width(k);
  localparam int CW = $clog2(2 * k);

  state_t         r_state;
  state_t         w_next;
  logic [2*k-1:0] r_dividend;
  logic [k-1:0]   r_divisor;
  logic [DW-1:0]  r_deg;
  // The accumulator's top bit is always cleared by the step XOR, so it is not stored.
  logic [k-2:0]   r_acc;
  logic [2*k-2:0] r_q;
  logic [CW-1:0]  r_cnt;
  logic [2*k-1:0] r_quotient;
  logic [k-1:0]   r_remainder;
  logic           r_dbz;

  logic [DW-1:0]  w_deg;
  logic           w_zero;
  logic           w_accept;
  logic           w_last;
  logic           w_bit;
  logic [k-1:0]   w_t;
  logic           w_qbit;
  logic [k-1:0]   w_acc_next;
  logic [2*k-1:0] w_q_next;

  gf2_degree #(.K(k), .DW(DW)) u_degree (
    .i_poly (divisor),
    .o_deg  (w_deg),
    .o_zero (w_zero)
  );

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;
  assign o_state     = r_state;

  assign w_accept   = in_valid && in_ready;
  assign w_last     = (r_cnt == '0);
  assign w_bit      = r_dividend[r_cnt];
  assign w_t        = {r_acc, w_bit};
  assign w_qbit     = w_t[r_deg];
  assign w_acc_next = w_qbit ? (w_t ^ r_divisor) : w_t;
  assign w_q_next   = {r_q, w_qbit};

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_zero ? DONE : DIV;
      DIV:     if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_deg       <= '0;
      r_acc       <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_dividend <= dividend;
            r_divisor  <= divisor;
            r_deg      <= w_deg;
            r_acc      <= '0;
            r_q        <= '0;
            r_cnt      <= CW'(2 * k - 1);
            if (w_zero) begin
              r_quotient  <= '0;
              r_remainder <= '0;
              r_dbz       <= 1'b1;
            end
          end
        end
        DIV: begin
          r_acc <= w_acc_next[k-2:0];
          r_q   <= w_q_next[2*k-2:0];
          r_cnt <= w_last ? '0 : r_cnt - CW'(1);
          if (w_last) begin
            r_quotient  <= w_q_next;
            r_remainder <= w_acc_next;
            r_dbz       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf2_poly_divider.sv
// Bench for gf2_poly_divider at k=4: directed cases, backpressure, abort and
// random operands, scored against an independent long-division model.
module tb_gf2_poly_divider;
  import gf2_pkg::*;

  localparam int K = 4;
  localparam int W = 2 * K + K + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2*K-1:0] dividend;
  logic [K-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [2*K-1:0] quotient;
  logic [K-1:0]   remainder;
  logic           div_by_zero;
  state_t         o_state;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  gf2_poly_divider #(.k(K)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .o_state     (o_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Classic long division over GF(2): packs {quotient, remainder, div_by_zero}.
  function automatic logic [W-1:0] model(input logic [2*K-1:0] dd, input logic [K-1:0] dv);
    logic [2*K-1:0] r, q, sh;
    int d;
    if (dv == '0) return {{(2*K){1'b0}}, {K{1'b0}}, 1'b1};
    d = 0;
    for (int i = 0; i < K; i++) if (dv[i]) d = i;
    r = dd;
    q = '0;
    for (int i = 2 * K - 1; i >= d; i--) begin
      if (r[i]) begin
        sh = {{K{1'b0}}, dv};
        r = r ^ (sh << (i - d));
        q[i-d] = 1'b1;
      end
    end
    return {q, r[K-1:0], 1'b0};
  endfunction

  function automatic logic [3*K-1:0] clmul(input logic [2*K-1:0] a, input logic [K-1:0] b);
    logic [3*K-1:0] p, aa;
    p = '0;
    aa = {{K{1'b0}}, a};
    for (int i = 0; i < K; i++) if (b[i]) p = p ^ (aa << i);
    return p;
  endfunction

  task automatic run_op(input logic [2*K-1:0] dd, input logic [K-1:0] dv, input int hold);
    int n;
    logic [W-1:0] exp;
    logic [3*K-1:0] prod;
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    check("ready_before", 32'(in_ready), 32'd1);
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    exp_q.push_back(model(dd, dv));
    step();
    in_valid = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    n = 1;
    while (!out_valid && n < 50) begin step(); n++; end
    check("latency", 32'(n), (dv == '0) ? 32'd1 : 32'(2 * K + 1));
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'(exp_q.size()), 32'd1);
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
    end
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      check("busy_ready", 32'(in_ready), 32'd0);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_q", 32'(quotient), 32'(exp[W-1:K+1]));
      check("hold_r", 32'(remainder), 32'(exp[K:1]));
      step();
    end
    in_valid = 1'b0;
    check("quotient", 32'(quotient), 32'(exp[W-1:K+1]));
    check("remainder", 32'(remainder), 32'(exp[K:1]));
    check("div_by_zero", 32'(div_by_zero), 32'(exp[0]));
    if (dv != '0) begin
      prod = clmul(quotient, dv) ^ {{(2*K){1'b0}}, remainder};
      check("identity", 32'(prod), 32'(dd));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("idle_ready", 32'(in_ready), 32'd1);
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_retain_q", 32'(quotient), 32'(exp[W-1:K+1]));
  endtask

  initial begin
    logic seen_valid;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    dividend = 8'hFF;
    divisor = 4'hF;
    step();
    step();
    rst = 1'b0;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_state", 32'(o_state), 32'(IDLE));

    run_op(8'h0F, 4'b0011, 0);
    run_op(8'h0F, 4'b0010, 0);
    run_op(8'h80, 4'b1011, 0);
    run_op(8'hA5, 4'b0000, 0);
    run_op(8'hA5, 4'b0001, 0);
    run_op(8'hFF, 4'b1000, 0);
    run_op(8'hC3, 4'b1011, 5);
    run_op(8'h3C, 4'b0000, 5);

    // Abort mid-division: no result may ever appear.
    dividend = 8'hB7;
    divisor  = 4'b1101;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b0;
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_q", 32'(quotient), 32'd0);
    check("abort_r", 32'(remainder), 32'd0);
    check("abort_dbz", 32'(div_by_zero), 32'd0);
    seen_valid = out_valid;
    for (int i = 0; i < 2 * K + 4; i++) begin
      step();
      seen_valid = seen_valid | out_valid;
    end
    check("abort_no_valid", 32'(seen_valid), 32'd0);

    for (int i = 0; i < 24; i++) begin
      run_op(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), $urandom_range(0, 2));
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
